// File: rtl/alu_vector_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_vector_driver_if
// Brief    : Bus between the vector driver (master) and a combinational ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_vector_driver_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_s;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_d;
    logic             alu_cout;
    logic             alu_v;

    modport master (
        output alu_a, alu_b, alu_s, alu_cin,
        input  alu_d, alu_cout, alu_v
    );

    modport slave (
        input  alu_a, alu_b, alu_s, alu_cin,
        output alu_d, alu_cout, alu_v
    );
endinterface
`default_nettype wire

// File: rtl/alu_vector_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_vector_driver
// Brief    : Self-test engine that applies a loadable vector table to an ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_vector_driver #(
    parameter int WIDTH  = 32,
    parameter int NVEC   = 32,
    parameter int SETTLE = 2,
    parameter int AW     = $clog2(NVEC),
    parameter int CW     = $clog2(NVEC + 1)
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              vec_we,
    input  wire [AW-1:0]     vec_addr,
    input  wire [2:0]        vec_s,
    input  wire              vec_cin,
    input  wire [WIDTH-1:0]  vec_a,
    input  wire [WIDTH-1:0]  vec_b,
    input  wire [WIDTH-1:0]  vec_exp_d,
    input  wire              vec_exp_c,
    input  wire              vec_exp_v,
    input  wire [2:0]        vec_chk,
    input  wire [CW-1:0]     num_vec,
    input  wire              start,
    alu_vector_driver_if.master alu,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    err_count,
    output logic [CW-1:0]    first_fail,
    output logic             fail_seen
);

    localparam int               c_SCW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_SCW-1:0] c_CNT_INIT = c_SCW'(SETTLE - 1);
    localparam logic [CW-1:0]    c_NVEC     = CW'(NVEC);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0]       s;
        logic             cin;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_d;
        logic             exp_c;
        logic             exp_v;
        logic [2:0]       chk;
    } entry_t;

    state_t           r_state;
    state_t           w_next;
    entry_t           r_tab [NVEC];
    entry_t           w_wr;
    entry_t           w_cur;
    logic [AW-1:0]    r_idx;
    logic [CW-1:0]    r_nvec;
    logic [c_SCW-1:0] r_cnt;
    logic [CW-1:0]    w_nclamp;
    logic             w_last;
    logic             w_mismatch;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_s;
    logic             r_alu_cin;
    logic             r_done;
    logic             r_pass;
    logic [CW-1:0]    r_err;
    logic [CW-1:0]    r_ff;
    logic             r_seen;

    assign w_wr       = {vec_s, vec_cin, vec_a, vec_b, vec_exp_d, vec_exp_c, vec_exp_v, vec_chk};
    assign w_cur      = r_tab[r_idx];
    assign w_nclamp   = (num_vec > c_NVEC) ? c_NVEC : num_vec;
    assign w_last     = (CW'(r_idx) == (r_nvec - CW'(1)));
    assign w_mismatch = (w_cur.chk[2] & (alu.alu_d    != w_cur.exp_d)) |
                        (w_cur.chk[1] & (alu.alu_cout != w_cur.exp_c)) |
                        (w_cur.chk[0] & (alu.alu_v    != w_cur.exp_v));

    // Table is storage only; it survives reset so a run can be repeated.
    always_ff @(posedge clk) begin
        if (vec_we && !busy) begin
            r_tab[vec_addr] <= w_wr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next = (w_nclamp == '0) ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY: begin
                busy   = 1'b1;
                w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy   = 1'b1;
                w_next = w_last ? ST_DONE : ST_APPLY;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= '0;
            r_nvec    <= '0;
            r_cnt     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_s   <= '0;
            r_alu_cin <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= '0;
            r_ff      <= '0;
            r_seen    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_idx  <= '0;
                        r_nvec <= w_nclamp;
                        r_err  <= '0;
                        r_ff   <= '0;
                        r_seen <= 1'b0;
                        r_done <= 1'b0;
                        r_pass <= (w_nclamp == '0);
                    end else if (r_state == ST_DONE) begin
                        // An empty run reaches DONE with done low; raise it here.
                        r_done <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    r_alu_a   <= w_cur.a;
                    r_alu_b   <= w_cur.b;
                    r_alu_s   <= w_cur.s;
                    r_alu_cin <= w_cur.cin;
                    r_cnt     <= c_CNT_INIT;
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_SCW'(1);
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= r_err + CW'(1);
                        if (!r_seen) begin
                            r_ff   <= CW'(r_idx);
                            r_seen <= 1'b1;
                        end
                    end
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_pass <= (r_err == '0) && !w_mismatch;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu.alu_a   = r_alu_a;
    assign alu.alu_b   = r_alu_b;
    assign alu.alu_s   = r_alu_s;
    assign alu.alu_cin = r_alu_cin;
    assign done        = r_done;
    assign pass        = r_pass;
    assign err_count   = r_err;
    assign first_fail  = r_ff;
    assign fail_seen   = r_seen;

endmodule
`default_nettype wire

// File: tb/tb_alu_vector_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_vector_driver
// Brief    : Directed vector-table bench for alu_vector_driver with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_vector_driver;

    localparam int WIDTH  = 32;
    localparam int NVEC   = 32;
    localparam int SETTLE = 2;
    localparam int AW     = 5;
    localparam int CW     = 6;

    typedef struct packed {
        logic [2:0]  s;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_c;
        logic        exp_v;
        logic [2:0]  chk;
    } vec_t;

    typedef struct {
        string         name;
        int            nload;
        int            ids [4];
        logic [CW-1:0] n;
        int            cyc;
        int            err;
        int            ff;
        logic          seen;
        logic          pss;
    } run_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vec_we = 1'b0;
    logic [AW-1:0] vec_addr = '0;
    logic [2:0]    vec_s = '0;
    logic          vec_cin = 1'b0;
    logic [31:0]   vec_a = '0;
    logic [31:0]   vec_b = '0;
    logic [31:0]   vec_exp_d = '0;
    logic          vec_exp_c = 1'b0;
    logic          vec_exp_v = 1'b0;
    logic [2:0]    vec_chk = '0;
    logic [CW-1:0] num_vec = '0;
    logic          start = 1'b0;
    logic          busy, done, pass, fail_seen;
    logic [CW-1:0] err_count, first_fail;

    int   total = 0;
    int   bad   = 0;
    vec_t vt [7];
    run_t runs [5];
    logic [WIDTH:0] m_sum;

    alu_vector_driver_if #(.WIDTH(WIDTH)) alu_bus ();

    alu_vector_driver #(
        .WIDTH(WIDTH), .NVEC(NVEC), .SETTLE(SETTLE), .AW(AW), .CW(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .vec_we(vec_we), .vec_addr(vec_addr), .vec_s(vec_s), .vec_cin(vec_cin),
        .vec_a(vec_a), .vec_b(vec_b), .vec_exp_d(vec_exp_d),
        .vec_exp_c(vec_exp_c), .vec_exp_v(vec_exp_v), .vec_chk(vec_chk),
        .num_vec(num_vec), .start(start), .alu(alu_bus.master),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail(first_fail), .fail_seen(fail_seen)
    );

    always #5 clk = ~clk;

    // Reference ALU: logic ops leave Cout/V at 0; 011 is a + ~b + cin.
    always_comb begin
        m_sum            = '0;
        alu_bus.alu_d    = '0;
        alu_bus.alu_cout = 1'b0;
        alu_bus.alu_v    = 1'b0;
        case (alu_bus.alu_s)
            3'b000: alu_bus.alu_d = alu_bus.alu_a ^ alu_bus.alu_b;
            3'b001: alu_bus.alu_d = ~(alu_bus.alu_a ^ alu_bus.alu_b);
            3'b010, 3'b011: begin
                m_sum = {1'b0, alu_bus.alu_a}
                      + {1'b0, (alu_bus.alu_s[0] ? ~alu_bus.alu_b : alu_bus.alu_b)}
                      + {{WIDTH{1'b0}}, alu_bus.alu_cin};
                alu_bus.alu_d    = m_sum[WIDTH-1:0];
                alu_bus.alu_cout = m_sum[WIDTH];
                alu_bus.alu_v    = (alu_bus.alu_a[31] == (alu_bus.alu_s[0] ^ alu_bus.alu_b[31]))
                                 && (m_sum[31] != alu_bus.alu_a[31]);
            end
            3'b100: alu_bus.alu_d = alu_bus.alu_a | alu_bus.alu_b;
            3'b101: alu_bus.alu_d = ~(alu_bus.alu_a | alu_bus.alu_b);
            3'b110: alu_bus.alu_d = alu_bus.alu_a & alu_bus.alu_b;
            default: alu_bus.alu_d = ~(alu_bus.alu_a & alu_bus.alu_b);
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int addr, input vec_t v);
        vec_addr  = AW'(addr);
        vec_s     = v.s;
        vec_cin   = v.cin;
        vec_a     = v.a;
        vec_b     = v.b;
        vec_exp_d = v.exp_d;
        vec_exp_c = v.exp_c;
        vec_exp_v = v.exp_v;
        vec_chk   = v.chk;
    endtask

    task automatic load(input int addr, input vec_t v);
        set_vec(addr, v);
        vec_we = 1'b1;
        tick();
        vec_we = 1'b0;
    endtask

    task automatic wait_done(inout int c);
        while (!done && c < 2000) begin
            tick();
            c++;
        end
    endtask

    task automatic check_result(input string name, input int c, input int cyc, input int err,
                                input int ff, input logic seen, input logic pss);
        check({name, " cycles"}, c, cyc);
        check({name, " done"}, done, 1'b1);
        check({name, " err_count"}, err_count, err);
        check({name, " first_fail"}, first_fail, ff);
        check({name, " fail_seen"}, fail_seen, seen);
        check({name, " pass"}, pass, pss);
    endtask

    task automatic run_check(input string name, input logic [CW-1:0] n, input int cyc,
                             input int err, input int ff, input logic seen, input logic pss);
        int c;
        num_vec = n;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check({name, " busy"}, busy, (n != 0));
        c = 0;
        wait_done(c);
        check_result(name, c, cyc, err, ff, seen, pss);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        vec_t v;

        vt[0] = '{3'b010, 1'b1, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 3'b111};
        vt[1] = '{3'b010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 3'b111};
        vt[2] = '{3'b110, 1'b0, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 3'b100};
        vt[3] = '{3'b011, 1'b1, 32'h31312020, 32'hCCEEDDFF, 32'h64424221, 1'b0, 1'b0, 3'b100};
        vt[4] = '{3'b110, 1'b0, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFE, 1'b0, 1'b0, 3'b100};
        vt[5] = '{3'b000, 1'b0, 32'hF01010CA, 32'hF00011AC, 32'h00100166, 1'b1, 1'b1, 3'b100};
        vt[6] = '{3'b000, 1'b0, 32'hF01010CA, 32'hF00011AC, 32'h00100166, 1'b1, 1'b1, 3'b111};

        runs[0] = '{"pass4",  4, '{0, 1, 2, 3}, 6'd4, 16, 0, 0, 1'b0, 1'b1};
        runs[1] = '{"fail2",  4, '{0, 1, 4, 3}, 6'd4, 16, 1, 2, 1'b1, 1'b0};
        runs[2] = '{"dc_ok",  1, '{5, 0, 0, 0}, 6'd1,  4, 0, 0, 1'b0, 1'b1};
        runs[3] = '{"dc_all", 1, '{6, 0, 0, 0}, 6'd1,  4, 1, 0, 1'b1, 1'b0};
        runs[4] = '{"empty",  0, '{0, 0, 0, 0}, 6'd0,  1, 0, 0, 1'b0, 1'b1};

        repeat (3) tick();
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst pass", pass, 1'b0);
        check("rst err_count", err_count, 0);
        check("rst alu_a", alu_bus.alu_a, 0);
        check("rst alu_s", alu_bus.alu_s, 0);
        #2 reset_n = 1'b1;
        tick();
        check("idle busy", busy, 1'b0);

        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < runs[r].nload; k++) begin
                load(k, vt[runs[r].ids[k]]);
            end
            run_check(runs[r].name, runs[r].n, runs[r].cyc, runs[r].err,
                      runs[r].ff, runs[r].seen, runs[r].pss);
        end

        // Operands of the last applied vector stay on the bus in DONE.
        repeat (3) tick();
        check("hold done", done, 1'b1);
        check("hold alu_a", alu_bus.alu_a, 32'hF01010CA);
        check("hold alu_b", alu_bus.alu_b, 32'hF00011AC);

        // Reset during the settle window of vector 1.
        for (int k = 0; k < 4; k++) load(k, vt[k]);
        num_vec = 6'd4;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("mid busy", busy, 1'b1);
        check("mid alu_a", alu_bus.alu_a, 32'hFFFFFFFF);
        #2 reset_n = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort alu_a", alu_bus.alu_a, 0);
        check("abort alu_b", alu_bus.alu_b, 0);
        check("abort alu_s", alu_bus.alu_s, 0);
        check("abort alu_cin", alu_bus.alu_cin, 1'b0);
        #2 reset_n = 1'b1;
        tick();
        tick();
        check("post rst busy", busy, 1'b0);
        check("post rst done", done, 1'b0);
        run_check("rerun", 6'd4, 16, 0, 0, 1'b0, 1'b1);

        // Write and start while busy must both be dropped.
        num_vec = 6'd4;
        start   = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        repeat (2) begin
            tick();
            c++;
        end
        v       = vt[0];
        v.exp_d = 32'h0;
        set_vec(0, v);
        vec_we  = 1'b1;
        num_vec = 6'd1;
        start   = 1'b1;
        tick();
        c++;
        vec_we = 1'b0;
        start  = 1'b0;
        check("busyprot busy", busy, 1'b1);
        wait_done(c);
        check_result("busyprot", c, 16, 0, 0, 1'b0, 1'b1);
        run_check("table kept", 6'd4, 16, 0, 0, 1'b0, 1'b1);

        // Write and start on the same edge: the new entry 0 is used.
        set_vec(0, vt[6]);
        vec_we  = 1'b1;
        num_vec = 6'd1;
        start   = 1'b1;
        tick();
        vec_we = 1'b0;
        start  = 1'b0;
        c = 0;
        wait_done(c);
        check_result("we+start", c, 4, 1, 0, 1'b1, 1'b0);

        // Full table, count above NVEC; only the last entry is wrong.
        for (int i = 0; i < NVEC; i++) begin
            v.s     = 3'b010;
            v.cin   = 1'b0;
            v.a     = 32'(i * 16 + 5);
            v.b     = 32'h00001000;
            v.exp_d = v.a + v.b + ((i == NVEC - 1) ? 32'd1 : 32'd0);
            v.exp_c = 1'b0;
            v.exp_v = 1'b0;
            v.chk   = 3'b111;
            load(i, v);
        end
        run_check("clamp", 6'd40, 128, 1, 31, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_vector_driver.md
Name: alu_vector_driver

Overview:
- Hardware initiator for the 32-bit ALU interface (a, b, S, Cin -> d, Cout, V).
- Holds a loadable table of test vectors and applies them to the ALU in sequence, waiting a programmable settle time for each.
- Compares d, Cout and V against expected values, with a per-field don't-care flag on each, and reports an error count, the first failing vector index and a pass flag.
- Sits beside the ALU as an on-chip self-test engine; the ALU itself stays combinational and unchanged.

Parameters:
- WIDTH, 32, ALU operand and result width.
- NVEC, 32, number of vector table entries.
- SETTLE, 2, cycles waited after applying a vector before sampling the ALU outputs (minimum 1).
- AW, $clog2(NVEC), vector address width.
- CW, $clog2(NVEC+1), width of the count and index outputs.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- vec_we  in  1  write strobe for a table entry; ignored while busy.
- vec_addr  in  AW  table entry index.
- vec_s  in  3  ALU opcode S.
- vec_cin  in  1  ALU carry-in.
- vec_a, vec_b  in  WIDTH  ALU operands.
- vec_exp_d  in  WIDTH  expected d.
- vec_exp_c  in  1  expected Cout.
- vec_exp_v  in  1  expected V.
- vec_chk  in  3  compare enables {d, Cout, V}; a 0 bit makes that field don't-care.
- num_vec  in  CW  number of vectors to run; sampled at start; values above NVEC are clamped to NVEC.
- start  in  1  run request; accepted only in IDLE or DONE.
- alu_a, alu_b  out  WIDTH  registered operands driven to the ALU.
- alu_s  out  3  registered opcode.
- alu_cin  out  1  registered carry-in.
- alu_d  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry-out.
- alu_v  in  1  ALU overflow.
- busy  out  1  high in APPLY, SETTLE and CHECK.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  valid when done: 1 iff err_count == 0.
- err_count  out  CW  number of failing vectors in the run.
- first_fail  out  CW  index of the first failing vector.
- fail_seen  out  1  high once any vector in the run has failed.

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE immediately.
  - All outputs go to 0, including alu_* and pass.
  - The vector table is not reset.
- Table write: when vec_we=1 and busy=0, all vector fields are written at vec_addr on the clk edge. Writes while busy are dropped.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1:
  - idx <- 0.
  - err_count, first_fail and fail_seen are cleared.
  - pass <- 0.
  - done <- 0.
  - Next state is APPLY, or DONE with pass=1 if the clamped num_vec is 0.
- APPLY (1 cycle): load alu_a/b/s/cin from table[idx]; settle counter <- SETTLE-1. Next state SETTLE.
- SETTLE (SETTLE cycles): alu_* held stable; counter decrements. Leaves for CHECK when the counter reaches 0.
- CHECK (1 cycle):
  - mismatch = (chk_d & alu_d!=exp_d) | (chk_c & alu_cout!=exp_c) | (chk_v & alu_v!=exp_v).
  - On mismatch: err_count increments; if fail_seen=0, first_fail <- idx and fail_seen <- 1.
  - If idx == num_vec-1: next state DONE, pass <- (final err_count == 0).
  - Otherwise: idx increments, next state APPLY.
- Latency:
  - Each vector takes SETTLE+2 cycles.
  - done rises N*(SETTLE+2) cycles after the edge that accepted start, where N is the clamped num_vec.
  - With N=0, done rises 1 cycle after that edge.
- alu_* outputs keep their last applied values in DONE and IDLE.
- start while busy is ignored.
- start and vec_we in the same cycle in IDLE: both take effect. The write lands before the first APPLY reads table[0].
- Reset asserted mid-run aborts the run with no partial result. After release the block sits in IDLE until the next start.
- err_count cannot overflow, since CW covers NVEC.

Test Plan:
1. Pass run (SETTLE=2):
   - Load v0: S=010, a=7FFFFFFF, b=0, cin=1, exp_d=80000000, c=0, v=1, chk=111.
   - Load v1: S=010, a=FFFFFFFF, b=FFFFFFFF, cin=0, exp_d=FFFFFFFE, c=1, v=0, chk=111.
   - Load v2: S=110, a=FFFFFFFF, b=0000FFFF, exp_d=0000FFFF, chk=100.
   - Load v3: S=011, a=31312020, b=CCEEDDFF, cin=1, exp_d=64424221, chk=100.
   - Set num_vec=4, pulse start -> busy for 16 cycles; done=1, pass=1, err_count=0.
2. Single failure: same table with v2 exp_d=0000FFFE -> err_count=1, first_fail=2, fail_seen=1, pass=0.
3. Don't-care fields:
   - Vector S=000, a=F01010CA, b=F00011AC, exp_d=00100166, chk=100, exp_c=1, exp_v=1 -> no error.
   - Same vector with chk=111 -> err_count=1, assuming the ALU drives Cout/V ≠ 1 for XOR.
4. Boundaries:
   - num_vec=0 -> done=1, pass=1 one cycle after start.
   - num_vec=40 -> clamped; 32 vectors run, done after 128 cycles.
5. Reset mid-run: drop reset_n during vector 1 SETTLE -> busy, done and alu_* are 0 immediately. Re-start gives the same result as scenario 1.
6. Busy protection: vec_we to v0 (exp_d=0) and a second start while busy -> both ignored. The run result is unchanged and the table still holds the old v0.
